// File: rtl/eth_axis_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_axis_frame_gen                                           |
// | Description : Ethernet frame generator driving the MAC TX AXIS byte        |
// |               stream. Each frame has a 14-byte header (DA, SA,             |
// |               length) and a patterned payload. Frame count, payload        |
// |               length and inter-frame gap are programmable.                 |
// |               Macro FRAME_GEN_PRBS_EN selects an 8-bit LFSR payload        |
// |               instead of the incrementing pattern.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eth_axis_frame_gen #(
  parameter logic [47:0] C_DST_MAC     = 48'h0102_0304_0506,
  parameter logic [47:0] C_SRC_MAC     = 48'h0A0B_0C0D_0E0F,
  parameter int          C_MIN_PAYLOAD = 46,
  parameter int          C_MAX_PAYLOAD = 1500,
  parameter int          C_CNT_WIDTH   = 16
) (
  input  logic                   tx_mac_aclk,
  input  logic                   tx_mac_resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic [C_CNT_WIDTH-1:0] frame_num,
  input  logic [10:0]            payload_len,
  input  logic [7:0]             gap_cycles,
  output logic [7:0]             tx_axis_mac_tdata,
  output logic                   tx_axis_mac_tvalid,
  output logic                   tx_axis_mac_tlast,
  input  logic                   tx_axis_mac_tready,
  output logic                   busy,
  output logic                   done,
  output logic [C_CNT_WIDTH-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [10:0] c_min_len  = 11'(C_MIN_PAYLOAD);
  localparam logic [10:0] c_max_len  = 11'(C_MAX_PAYLOAD);
  localparam logic [10:0] c_hdr_last = 11'd13;

  state_t                 state_q, state_d;
  logic [10:0]            idx_q, idx_d;        // byte index within HDR or PAY
  logic [10:0]            len_q, len_d;        // clamped payload length
  logic [C_CNT_WIDTH-1:0] num_q, num_d;
  logic [7:0]             gap_q, gap_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [C_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                   stop_q, stop_d;      // stop seen at any point in the run

  logic                   w_xfer;
  logic                   w_stop;
  logic                   w_pay_last;
  logic [10:0]            w_len_clamped;
  logic [C_CNT_WIDTH-1:0] w_cnt_inc;
  logic [111:0]           w_hdr;
  logic [111:0]           w_hdr_sh;
  logic [7:0]             w_pay_byte;

  assign w_len_clamped = (payload_len < c_min_len) ? c_min_len :
                         (payload_len > c_max_len) ? c_max_len : payload_len;
  assign w_xfer        = tx_axis_mac_tvalid & tx_axis_mac_tready;
  assign w_stop        = stop | stop_q;
  assign w_pay_last    = (idx_q == (len_q - 11'd1));
  assign w_cnt_inc     = frame_cnt_q + 1'b1;

  // Header is one 14-byte vector; the current byte is shifted up to the top.
  assign w_hdr    = {C_DST_MAC, C_SRC_MAC, 5'b00000, len_q};
  assign w_hdr_sh = w_hdr << {idx_q[3:0], 3'b000};

`ifdef FRAME_GEN_PRBS_EN
  logic [7:0] lfsr_q, lfsr_d;

  // LFSR reloads to its seed outside PAY and advances on each payload transfer.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q != S_PAY) begin
      lfsr_d = 8'h01;
    end else if (w_xfer) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // LFSR state register.
  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) lfsr_q <= 8'h01;
    else                lfsr_q <= lfsr_d;
  end

  assign w_pay_byte = lfsr_q;
`else
  assign w_pay_byte = frame_cnt_q[7:0] + idx_q[7:0];
`endif

  // Next-state logic: frame sequencing, byte indexing and run bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    num_d       = num_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    stop_d      = stop_q | stop;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_HDR;
          idx_d       = 11'd0;
          len_d       = w_len_clamped;
          num_d       = frame_num;
          gap_d       = gap_cycles;
          frame_cnt_d = '0;
          stop_d      = stop;
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          if (idx_q == c_hdr_last) begin
            idx_d   = 11'd0;
            state_d = S_PAY;
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end
      S_PAY: begin
        if (w_xfer) begin
          if (w_pay_last) begin
            idx_d       = 11'd0;
            frame_cnt_d = w_cnt_inc;
            if (w_stop || ((num_q != '0) && (w_cnt_inc == num_q))) begin
              state_d = S_DONE;
            end else if (gap_q != 8'd0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
            end else begin
              state_d = S_HDR;
            end
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end
      S_GAP: begin
        if (w_stop) begin
          state_d = S_DONE;
        end else if (gap_cnt_q == 8'd1) begin
          state_d = S_HDR;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= 11'd0;
      len_q       <= 11'd0;
      num_q       <= '0;
      gap_q       <= 8'd0;
      gap_cnt_q   <= 8'd0;
      frame_cnt_q <= '0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      num_q       <= num_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      stop_q      <= stop_d;
    end
  end

  // Outputs decode straight from registered state so they hold under backpressure.
  always_comb begin
    tx_axis_mac_tdata = 8'h00;
    if (state_q == S_HDR)      tx_axis_mac_tdata = w_hdr_sh[111:104];
    else if (state_q == S_PAY) tx_axis_mac_tdata = w_pay_byte;
  end

  assign tx_axis_mac_tvalid = (state_q == S_HDR) || (state_q == S_PAY);
  assign tx_axis_mac_tlast  = (state_q == S_PAY) && w_pay_last;
  assign busy               = (state_q == S_HDR) || (state_q == S_PAY) || (state_q == S_GAP);
  assign done               = (state_q == S_DONE);
  assign frame_cnt          = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_axis_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_eth_axis_frame_gen                                        |
// | Description : Scoreboard bench for eth_axis_frame_gen. Stimulus pushes     |
// |               the expected byte stream of each run; a monitor pops on      |
// |               every AXIS transfer and checks stall/gap behaviour.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_eth_axis_frame_gen;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] frame_num = '0;
  logic [10:0]   payload_len = 11'd0;
  logic [7:0]    gap_cycles = 8'd0;
  logic          tready = 1'b0;
  logic [7:0]    tdata;
  logic          tvalid, tlast, busy, done;
  logic [CW-1:0] frame_cnt;

  eth_axis_frame_gen dut (
    .tx_mac_aclk        (clk),
    .tx_mac_resetn      (rst_n),
    .start              (start),
    .stop               (stop),
    .frame_num          (frame_num),
    .payload_len        (payload_len),
    .gap_cycles         (gap_cycles),
    .tx_axis_mac_tdata  (tdata),
    .tx_axis_mac_tvalid (tvalid),
    .tx_axis_mac_tlast  (tlast),
    .tx_axis_mac_tready (tready),
    .busy               (busy),
    .done               (done),
    .frame_cnt          (frame_cnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];          // {tlast, tdata}
  int         exp_gap = 0;
  int         mode = 0;          // 0 always ready, 1 toggling, 2 random 3-cycle stalls
  int         cyc = 0;
  int         xfer_cnt = 0;
  int         frames_seen = 0;
  int         last_tlast_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // tready driver
  initial begin
    int stall_left;
    stall_left = 0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: tready = 1'b1;
        1: tready = ~tready;
        default: begin
          if (stall_left > 0) begin
            tready = 1'b0;
            stall_left--;
          end else if ($urandom_range(0, 7) == 0) begin
            tready = 1'b0;
            stall_left = 2;
          end else begin
            tready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: scoreboard pop, stall stability, no holes in a frame, gap length.
  initial begin
    logic [7:0] pd;
    logic       pl;
    logic [8:0] e;
    bit         pstall, in_frame, gap_on;
    int         gcnt;
    pd = 8'h00; pl = 1'b0; pstall = 0; in_frame = 0; gap_on = 0; gcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pstall = 0; in_frame = 0; gap_on = 0;
      end else begin
        if (pstall) begin
          chk("stall_tvalid", tvalid, 1'b1);
          chk("stall_tdata", tdata, pd);
          chk("stall_tlast", tlast, pl);
        end else if (in_frame) begin
          chk("frame_tvalid", tvalid, 1'b1);
        end
        if (gap_on) begin
          if (!busy) gap_on = 0;
          else if (tvalid) begin
            chk("gap_len", gcnt, exp_gap);
            gap_on = 0;
          end else gcnt++;
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) fail_now("unexpected_byte");
          else begin
            e = exp_q.pop_front();
            chk("tdata", tdata, e[7:0]);
            chk("tlast", tlast, e[8]);
          end
          xfer_cnt++;
          in_frame = !tlast;
          if (tlast) begin
            frames_seen++;
            last_tlast_cyc = cyc;
            gap_on = 1;
            gcnt = 0;
          end
        end
        pstall = tvalid && !tready;
        pd = tdata;
        pl = tlast;
      end
    end
  end

  function automatic int clamp(input int len);
    return (len < 46) ? 46 : (len > 1500) ? 1500 : len;
  endfunction

  // Reference frames: header then payload pattern, tlast on the final byte.
  task automatic push_frames(input int L, input int nfr);
    logic [47:0] da, sa;
    logic [10:0] lv;
`ifdef FRAME_GEN_PRBS_EN
    logic [7:0] lf;
`endif
    da = 48'h0102_0304_0506;
    sa = 48'h0A0B_0C0D_0E0F;
    lv = 11'(L);
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, da[47-8*i -: 8]});
      for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, sa[47-8*i -: 8]});
      exp_q.push_back({1'b0, 5'b00000, lv[10:8]});
      exp_q.push_back({1'b0, lv[7:0]});
`ifdef FRAME_GEN_PRBS_EN
      lf = 8'h01;
      for (int k = 0; k < L; k++) begin
        exp_q.push_back({(k == L - 1), lf});
        lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      end
`else
      for (int k = 0; k < L; k++) exp_q.push_back({(k == L - 1), 8'((f + k) % 256)});
`endif
    end
  endtask

  // Issue a start pulse and check the first byte appears the next cycle.
  task automatic do_start(input int num, input int len, input int gap, input bit stp);
    @(posedge clk);
    #1;
    frame_num = CW'(num);
    payload_len = 11'(len);
    gap_cycles = 8'(gap);
    stop = stp;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    frame_num = CW'($urandom);
    payload_len = 11'($urandom);
    gap_cycles = 8'($urandom);
    @(negedge clk);
    chk("start_tvalid", tvalid, 1'b1);
    chk("start_busy", busy, 1'b1);
    chk("start_tdata", tdata, 8'h01);
  endtask

  task automatic run(input int num, input int len, input int gap, input int md,
                     input int stop_frame, input bit stop_at_start);
    int nfr, base_f, xb, t;
    nfr = stop_at_start ? 1 : (num == 0 ? stop_frame : num);
    mode = md;
    exp_gap = gap;
    push_frames(clamp(len), nfr);
    base_f = frames_seen;
    do_start(num, len, gap, stop_at_start);
    // a second start mid-run must be ignored
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (num == 0 && !stop_at_start) begin
      t = 0;
      while ((frames_seen - base_f) < stop_frame - 1 && t < 40000) begin
        @(negedge clk);
        t++;
      end
      xb = xfer_cnt;
      while ((xfer_cnt - xb) < 20 && t < 40000) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk);
      #1 stop = 1'b1;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 40000);
    if (!done) fail_now("done_timeout");
    else begin
      chk("done_after_tlast", cyc, last_tlast_cyc + 1);
      chk("done_busy", busy, 1'b0);
      chk("done_frame_cnt", frame_cnt, nfr);
      chk("frames_seen", frames_seen - base_f, nfr);
      chk("queue_empty", exp_q.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("frame_cnt_hold", frame_cnt, nfr);
    end
    @(posedge clk);
    #1 stop = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int xb, t;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tvalid", tvalid, 1'b0);

    run(1, 46, 0, 0, 0, 0);           // single minimum frame
    run(1, 46, 0, 1, 0, 0);           // toggling tready
    run(1, 46, 0, 2, 0, 0);           // random stalls
    run(3, 10, 12, 0, 0, 0);          // lower clamp, gaps
    run(0, 2000, 3, 1, 2, 0);         // upper clamp, continuous, stop in frame 2
    run(0, 50, 5, 0, 0, 1);           // start and stop together

    // reset in the middle of the second frame's payload
    mode = 2;
    exp_gap = 0;
    push_frames(100, 2);
    xb = xfer_cnt;
    do_start(3, 100, 0, 1'b0);
    t = 0;
    while ((xfer_cnt - xb) < 114 + 44 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if ((xfer_cnt - xb) < 158) fail_now("reset_wait_timeout");
    chk("pre_reset_frame_cnt", frame_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", tvalid, 1'b0);
    chk("async_rst_tlast", tlast, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run(2, 80, 0, 2, 0, 0);

    for (int r = 0; r < 6; r++) begin
      run($urandom_range(1, 3), $urandom_range(0, 220), $urandom_range(0, 15),
          $urandom_range(0, 2), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_axis_frame_gen.md
Name: eth_axis_frame_gen

Overview:
Synthesisable Ethernet frame generator that drives the tx_axis_mac byte stream of tri_mode_ethernet_mac. It replaces hand-sequenced bench stimulus with a parametrised engine. Each frame carries a full header (DA, SA, length/type) and a patterned payload, with a programmable frame count, payload length and inter-frame gap. It sits in the tx_mac_aclk domain, in front of the MAC TX AXIS port, for loopback bring-up and link soak testing.

Parameters:
C_DST_MAC, 48'h0102_0304_0506, destination MAC placed in bytes 0-5 (MSB first)
C_SRC_MAC, 48'h0A0B_0C0D_0E0F, source MAC placed in bytes 6-11 (MSB first)
C_MIN_PAYLOAD, 46, lower clamp on payload length (bytes)
C_MAX_PAYLOAD, 1500, upper clamp on payload length (bytes)
C_CNT_WIDTH, 16, width of frame_num and frame_cnt

Ports:
tx_mac_aclk  in  1  clock
tx_mac_resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle start pulse, honoured only in IDLE
stop  in  1  level; when sampled high, the current frame completes and the engine then returns to IDLE
frame_num  in  C_CNT_WIDTH  frames to send; 0 = continuous until stop
payload_len  in  11  payload bytes per frame before clamping
gap_cycles  in  8  idle cycles between frames, added after tlast
tx_axis_mac_tdata  out  8  frame byte
tx_axis_mac_tvalid  out  1  byte valid
tx_axis_mac_tlast  out  1  last payload byte
tx_axis_mac_tready  in  1  MAC accepts byte
busy  out  1  high from start acceptance until DONE
done  out  1  one-cycle pulse when the run ends
frame_cnt  out  C_CNT_WIDTH  frames fully transferred in the current run

Behaviour:
- Reset (asynchronous, tx_mac_resetn=0) forces all outputs to 0 and the FSM to IDLE immediately, including mid-frame. Release is sampled on the clock.
- States: IDLE, HDR, PAY, GAP, DONE.
- IDLE:
  - start=1 latches frame_num, gap_cycles and the clamped payload_len (L).
  - Clamping: L < C_MIN_PAYLOAD becomes C_MIN_PAYLOAD; L > C_MAX_PAYLOAD becomes C_MAX_PAYLOAD.
  - On start: frame_cnt is cleared, busy goes high the next cycle, and the FSM goes to HDR.
- Latency: start in cycle N gives tvalid=1 with DA byte 0 in cycle N+1.
- HDR: 14 bytes are sent.
  - Bytes 0-5 are C_DST_MAC, bytes 6-11 are C_SRC_MAC.
  - Bytes 12-13 are L, big-endian.
  - After byte 13 the FSM goes to PAY.
- PAY: L bytes are sent.
  - Payload byte k = (frame_cnt[7:0] + k) mod 256.
  - tlast=1 on byte L-1 only.
- AXIS rules:
  - A byte transfers on a cycle with tvalid & tready.
  - tdata, tvalid and tlast are held stable while tready=0.
  - tvalid never drops inside a frame (HDR through the last PAY byte).
- Frame completion: on transfer of the tlast byte, frame_cnt increments (wraps modulo 2^C_CNT_WIDTH). The next state is then chosen as:
  - DONE if stop=1 or frame_cnt+1 == frame_num (frame_num != 0);
  - otherwise GAP if gap_cycles > 0;
  - otherwise HDR, giving back-to-back frames.
- GAP: tvalid=0 for exactly gap_cycles cycles, then HDR. stop=1 during GAP goes to DONE at the next edge.
- DONE: one cycle with done=1 and busy=0, then IDLE. frame_cnt holds its value until the next start.
- start outside IDLE is ignored. start and stop both high in IDLE: start wins, and exactly one frame is sent.
- payload_len, frame_num and gap_cycles changing mid-run have no effect; they are latched only at start.

Optional Feature:
FRAME_GEN_PRBS_EN
- Defined: payload bytes come from an 8-bit LFSR.
  - Next state = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Seed 8'h01 is reloaded at every frame start; byte k = LFSR state after k advances.
  - Sequence: 01, 02, 04, 08, 11, 23, ...
- Undefined: incrementing pattern as above, and no LFSR logic is synthesised.

Test Plan:
- Single frame: frame_num=1, payload_len=46, gap=0, tready=1 -> 60 bytes. Bytes 0-5 are 01 02 03 04 05 06, bytes 12-13 are 00 2E, payload 00..2D, tlast on byte 59 only. frame_cnt=1, done pulse 1 cycle after tlast.
- Backpressure: the same frame with tready toggling 1-0 every cycle and random 3-cycle stalls -> identical byte sequence, with tdata/tlast stable while stalled and no tvalid gaps.
- Clamp and multi-frame: payload_len=10, frame_num=3, gap=12 -> three 60-byte frames with length field 00 2E. Second frame payload starts 01, third starts 02. Exactly 12 idle cycles between frames; frame_cnt=3.
- Upper clamp, continuous mode: payload_len=2000, frame_num=0 -> 1514-byte frames with length field 05 DC. stop asserted mid-frame 2 -> frame 2 completes, done, frame_cnt=2.
- Reset mid-payload: assert tx_mac_resetn=0 at byte 30 -> tvalid, tlast, busy and frame_cnt are 0 asynchronously. After release, start gives a clean frame from DA byte 0.
- PRBS build (FRAME_GEN_PRBS_EN): the first six payload bytes of every frame are 01 02 04 08 11 23.
